// File: rtl/registrador_pkg.sv
// registrador_pkg: shared depth default and per-stage reset value for the registrador delay line
package registrador_pkg;
  localparam int REGISTRADOR_DEFAULT_DEPTH = 4;
  localparam logic REGISTRADOR_RESET_VAL = 1'b0;
endpackage

// File: rtl/registrador_if.sv
// registrador_if: serial data port of the delay line; the taps view exists only with REGISTRADOR_TAP_EN
interface registrador_if
  import registrador_pkg::*;
#(
  parameter int DEPTH = REGISTRADOR_DEFAULT_DEPTH
);
  logic Shift_in;
  logic shift_out;
`ifdef REGISTRADOR_TAP_EN
  logic [DEPTH-1:0] taps;
  modport master (output Shift_in, input shift_out, input taps);
  modport slave (input Shift_in, output shift_out, output taps);
`else
  modport master (output Shift_in, input shift_out);
  modport slave (input Shift_in, output shift_out);
`endif
endinterface

// File: rtl/registrador_cell.sv
// registrador_cell: one-bit D flip-flop with synchronous active-low clear
module registrador_cell
  import registrador_pkg::*;
(
  input  logic CLK,
  input  logic Reset,
  input  logic d,
  output logic q
);
  always_ff @(posedge CLK)
    q <= !Reset ? REGISTRADOR_RESET_VAL : d;
endmodule

// File: rtl/registrador.sv
// registrador: DEPTH-stage serial-in/serial-out shift register; REGISTRADOR_TAP_EN exposes all stages on taps
module registrador
  import registrador_pkg::*;
#(
  parameter int DEPTH = REGISTRADOR_DEFAULT_DEPTH
) (
  input logic CLK,
  input logic Reset,
  registrador_if.slave bus
);
  logic [DEPTH-1:0] stage;
  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    if (g == 0) begin : g_head
      registrador_cell u_cell (.CLK(CLK), .Reset(Reset), .d(bus.Shift_in), .q(stage[g]));
    end else begin : g_body
      registrador_cell u_cell (.CLK(CLK), .Reset(Reset), .d(stage[g-1]), .q(stage[g]));
    end
  end
  assign bus.shift_out = stage[DEPTH-1];
`ifdef REGISTRADOR_TAP_EN
  assign bus.taps = stage;
`endif
endmodule

// File: tb/tb_registrador.sv
// tb_registrador: directed checks of the DEPTH=4 and DEPTH=1 delay lines; taps checked when REGISTRADOR_TAP_EN is defined
module tb_registrador;
  logic CLK = 1'b0;
  logic Reset = 1'b0;
  int compared = 0;
  int mismatched = 0;
  registrador_if #(.DEPTH(4)) bus4 ();
  registrador_if #(.DEPTH(1)) bus1 ();
  registrador #(.DEPTH(4)) u4 (.CLK(CLK), .Reset(Reset), .bus(bus4));
  registrador #(.DEPTH(1)) u1 (.CLK(CLK), .Reset(Reset), .bus(bus1));
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic rst_n, input logic din);
    Reset = rst_n;
    bus4.Shift_in = din;
    bus1.Shift_in = din;
    @(posedge CLK);
    #1;
  endtask
  task automatic check_taps(input string tag, input logic [3:0] exp);
`ifdef REGISTRADOR_TAP_EN
    check(tag, {28'd0, bus4.taps}, {28'd0, exp});
`else
    check(tag, {31'd0, bus4.shift_out}, {31'd0, exp[3]});
`endif
  endtask
  initial begin
    logic [3:0] pat_taps [4] = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
    logic pat_in [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic drain_out [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic pulse_out [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bus4.Shift_in = 1'b0;
    bus1.Shift_in = 1'b0;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check_taps("reset_taps", 4'b0000);
    check("reset_out4", {31'd0, bus4.shift_out}, 32'd0);
    check("reset_out1", {31'd0, bus1.shift_out}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, pat_in[i]);
      check_taps($sformatf("pattern_taps%0d", i), pat_taps[i]);
      check($sformatf("pattern_out1_%0d", i), {31'd0, bus1.shift_out}, {31'd0, pat_in[i]});
    end
    check("pattern_out4", {31'd0, bus4.shift_out}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      check($sformatf("drain_out%0d", i), {31'd0, bus4.shift_out}, {31'd0, drain_out[i]});
    end
    check_taps("drain_taps", 4'b0000);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    check_taps("load_taps", 4'b1111);
    step(1'b0, 1'b1);
    check_taps("midreset_taps", 4'b0000);
    check("midreset_out4", {31'd0, bus4.shift_out}, 32'd0);
    check("midreset_out1", {31'd0, bus1.shift_out}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, i == 0);
      check($sformatf("pulse_out4_%0d", i), {31'd0, bus4.shift_out}, {31'd0, pulse_out[i]});
      check($sformatf("pulse_out1_%0d", i), {31'd0, bus1.shift_out}, {31'd0, i == 0});
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
